// File: rtl/aes32_cmac_tag_check.sv
// Captures the 8-word dual-stream CMAC tag after a DONE rising edge and checks both streams
// against a writable expected-tag store. Define CMAC_TAG_ERRCNT_EN to add the ERR_CNT output.
module aes32_cmac_tag_check #(
  parameter int unsigned DLY = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        DONE,
  input  logic [31:0] DOUT,
  input  logic        EXP_WE,
  input  logic        EXP_SEL,
  input  logic [1:0]  EXP_IDX,
  input  logic [31:0] EXP_DIN,
  input  logic [2:0]  TLEN,
  output logic        BUSY,
  output logic        VALID,
  output logic        PASS1,
  output logic        PASS2,
  output logic        OVERRUN
`ifdef CMAC_TAG_ERRCNT_EN
  ,
  output logic [7:0]  ERR_CNT
`endif
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned WAIT_W = 2;
  localparam int unsigned TLEN_W = 3;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((DLY > 1) ? DLY - 1 : 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAP,
    S_RESULT
  } state_e;

  state_e                      state_q;
  logic                        done_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [WAIT_W-1:0]           wait_q;
  logic [TLEN_W-1:0]           tlen_q;
  logic                        mism1_q;
  logic                        mism2_q;
  logic [1:0][3:0][WORD_W-1:0] exp_q;

  logic              rise_c;
  logic [TLEN_W-1:0] tlen_eff_c;
  logic              cmp_en_c;
  logic              word_bad_c;
  logic              mism1_d;
  logic              mism2_d;

  // Edge detect, length clamp and per-word compare of the word on DOUT this cycle
  always_comb begin
    rise_c     = DONE & ~done_q;
    tlen_eff_c = TLEN;
    if (TLEN == TLEN_W'(0) || TLEN > TLEN_W'(4)) begin
      tlen_eff_c = TLEN_W'(4);
    end
    cmp_en_c   = {1'b0, cnt_q[1:0]} < tlen_q;
    word_bad_c = cmp_en_c && (DOUT != exp_q[cnt_q[2]][cnt_q[1:0]]);
    mism1_d    = mism1_q | (word_bad_c & ~cnt_q[2]);
    mism2_d    = mism2_q | (word_bad_c &  cnt_q[2]);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      wait_q  <= '0;
      tlen_q  <= '0;
      mism1_q <= 1'b0;
      mism2_q <= 1'b0;
      exp_q   <= '0;
      BUSY    <= 1'b0;
      VALID   <= 1'b0;
      PASS1   <= 1'b0;
      PASS2   <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      done_q <= DONE;
      VALID  <= 1'b0;
      if (rise_c && state_q != S_IDLE) begin
        OVERRUN <= 1'b1;
      end
      // The store is frozen while a capture is using it
      if (EXP_WE && !BUSY) begin
        exp_q[EXP_SEL][EXP_IDX] <= EXP_DIN;
      end
      case (state_q)
        S_IDLE: begin
          if (rise_c) begin
            tlen_q  <= tlen_eff_c;
            mism1_q <= 1'b0;
            mism2_q <= 1'b0;
            cnt_q   <= '0;
            wait_q  <= WAIT_W'(1);
            BUSY    <= 1'b1;
            state_q <= (DLY > 1) ? S_WAIT : S_CAP;
          end
        end
        S_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_q <= S_CAP;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_CAP: begin
          mism1_q <= mism1_d;
          mism2_q <= mism2_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) begin
            state_q <= S_RESULT;
            BUSY    <= 1'b0;
            VALID   <= 1'b1;
            PASS1   <= ~mism1_d;
            PASS2   <= ~mism2_d;
          end
        end
        S_RESULT: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CMAC_TAG_ERRCNT_EN
  logic [8:0] err_sum_c;

  // Failing streams of the just-finished capture, saturating at 255
  always_comb begin
    err_sum_c = {1'b0, ERR_CNT} + {8'd0, !PASS1} + {8'd0, !PASS2};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ERR_CNT <= '0;
    end else if (state_q == S_RESULT) begin
      ERR_CNT <= (err_sum_c > 9'd255) ? 8'hFF : err_sum_c[7:0];
    end
  end
`endif

endmodule
